// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The loader FSM state enum plus the byte-packing constants
// used by both the top level and the word assembler.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

  // Bytes needed to build one instruction word (little-endian order).
  localparam int BYTES_PER_WORD = 3;

  // Bits of the final byte that lie above the instruction width and must be zero.
  localparam logic [7:0] PAD_MASK = 8'hF0;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs three accepted bytes into one instruction word, little-endian.
// Latency: the word is registered on the third byte and valid the following cycle.
// Backpressure: none of its own; it only advances on bytes the parent accepts.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  byte_en,
  input  logic [7:0]            byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_complete,
  output logic                  pad_error
);

  // Number of instruction bits taken from the final byte.
  localparam int HI_BITS = DATA_WIDTH - 16;

  logic [1:0] byte_idx;
  logic [7:0] b0;
  logic [7:0] b1;

  // The third byte closes a word; any set bit above the instruction width is a malformed image.
  assign word_complete = byte_en && (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign pad_error     = word_complete && ((byte_data & PAD_MASK) != 8'h00);

  // Byte index counter and byte buffers; the finished word is captured for the write cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx <= 2'd0;
      b0       <= 8'h00;
      b1       <= 8'h00;
      word     <= '0;
    end else if (clr) begin
      byte_idx <= 2'd0;
      b0       <= 8'h00;
      b1       <= 8'h00;
      word     <= '0;
    end else if (byte_en) begin
      case (byte_idx)
        2'd0: begin
          b0       <= byte_data;
          byte_idx <= 2'd1;
        end
        2'd1: begin
          b1       <= byte_data;
          byte_idx <= 2'd2;
        end
        default: begin
          word     <= {byte_data[HI_BITS-1:0], b1, b0};
          byte_idx <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program image into instruction memory, holding the CPU in reset meanwhile.
// Latency: one cycle from acceptance of a word's third byte to its mem_we strobe.
// Backpressure: in_ready drops for the single write cycle of every word and outside loading.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDRESS_WIDTH = 8,
  parameter int MEM_SIZE      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_rst_n,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [ADDRESS_WIDTH:0]   word_count
);

  localparam logic [ADDRESS_WIDTH:0] LAST_ADDR = (ADDRESS_WIDTH + 1)'(MEM_SIZE - 1);

  loader_state_t state;
  loader_state_t state_nxt;

  logic                  load_start;
  logic                  data_byte;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_complete;
  logic                  pad_error;

  // A new load may only begin from a resting state; start during a load is ignored.
  assign load_start = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  // Image data bytes are only those taken in RECV; the checksum byte is not packed.
  assign data_byte  = in_valid && in_ready && (state == RECV);

  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_assembler (
    .clk          (clk),
    .rst          (rst),
    .clr          (load_start),
    .byte_en      (data_byte),
    .byte_data    (in_data),
    .word         (word),
    .word_complete(word_complete),
    .pad_error    (pad_error)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Address counter and the end-of-image flag captured with each word's last byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count <= '0;
      last_q     <= 1'b0;
    end else if (load_start) begin
      word_count <= '0;
      last_q     <= 1'b0;
    end else begin
      if (state == WRITE) word_count <= word_count + 1'b1;
      if (word_complete)  last_q     <= in_last;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over every image data byte, compared against the trailing check byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            csum <= 8'h00;
    else if (load_start) csum <= 8'h00;
    else if (data_byte)  csum <= csum ^ in_data;
  end
`endif

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rst_n = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RECV;
      end
      RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (word_complete) state_nxt = pad_error ? ERROR : WRITE;
          else if (in_last)  state_nxt = ERROR;
        end
      end
      WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = word_count[ADDRESS_WIDTH-1:0];
        mem_wdata = word;
        if (last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else if (word_count == LAST_ADDR) begin
          state_nxt = ERROR;
        end else begin
          state_nxt = RECV;
        end
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? DONE : ERROR;
`else
        state_nxt = ERROR;
`endif
      end
      DONE: begin
        done      = 1'b1;
        cpu_rst_n = !start;
        if (start) state_nxt = RECV;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_nxt = RECV;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
// Honours IMEM_LOADER_CHECKSUM_EN the same way as the design.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [19:0] mem_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  word_count;

  int checks = 0;
  int errors = 0;

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stream under test and the writes the model expects / the DUT produced.
  logic [7:0]  s_data[$];
  bit          s_last[$];
  logic [7:0]  e_addr[$];
  logic [19:0] e_data[$];
  logic [7:0]  g_addr[$];
  logic [19:0] g_data[$];

  // Write capture, plus: while loading, the loader is ready exactly when not writing.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_we) begin
        g_addr.push_back(mem_addr);
        g_data.push_back(mem_wdata);
      end
      if (busy) chk("ready_vs_write", {31'd0, in_ready}, {31'd0, !mem_we});
    end
  end

  task automatic clear_stream();
    s_data.delete();
    s_last.delete();
  endtask

  task automatic add_byte(input logic [7:0] b, input bit l);
    s_data.push_back(b);
    s_last.push_back(l);
  endtask

  task automatic add_word(input logic [19:0] w, input bit l);
    add_byte(w[7:0], 1'b0);
    add_byte(w[15:8], 1'b0);
    add_byte({4'h0, w[19:16]}, l);
  endtask

  // Appends the correct check byte when the checksum feature is built in.
  task automatic add_cs();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (s_data[i]) x = x ^ s_data[i];
    add_byte(x, 1'b0);
`endif
  endtask

  // Reference: walk the byte stream by the image rules and predict writes and outcome.
  task automatic model(output int used, output bit err, output int wc);
    int         idx;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] cs;
    logic [7:0] b;
    idx = 0; b0 = 0; b1 = 0; cs = 0;
    e_addr.delete();
    e_data.delete();
    used = s_data.size();
    err  = 1'b1;
    wc   = 0;
    for (int i = 0; i < s_data.size(); i++) begin
      b  = s_data[i];
      cs = cs ^ b;
      if (idx < 2) begin
        if (idx == 0) b0 = b;
        else          b1 = b;
        if (s_last[i]) begin
          used = i + 1;
          err  = 1'b1;
          return;
        end
        idx++;
      end else begin
        if (b > 8'h0F) begin
          used = i + 1;
          err  = 1'b1;
          return;
        end
        e_addr.push_back(8'(wc));
        e_data.push_back({b[3:0], b1, b0});
        wc++;
        idx = 0;
        if (s_last[i]) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          used = i + 2;
          err  = (s_data[i+1] != cs);
`else
          used = i + 1;
          err  = 1'b0;
`endif
          return;
        end
        if (wc == 256) begin
          used = i + 1;
          err  = 1'b1;
          return;
        end
      end
    end
  endtask

  // Offer one byte after `gap` idle cycles and hold it until accepted (bounded).
  task automatic send(input logic [7:0] b, input bit l, input int gap);
    int t;
    t = 0;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 40) begin
        chk("handshake_timeout", {31'd0, in_ready}, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Start a load, feed the bytes the model says will be consumed, then compare everything.
  task automatic run_load(input string tag, input int gmode);
    int used;
    int wc;
    int t;
    bit err;
    int n;
    model(used, err, wc);
    g_addr.delete();
    g_data.delete();
    start = 1'b1;
    @(negedge clk);
    chk({tag, "_start_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_cleared_count"}, {23'd0, word_count}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < used; i++)
      send(s_data[i], s_last[i], (gmode < 0) ? int'($urandom_range(0, 2)) : gmode);
    t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    chk({tag, "_nwrites"}, g_addr.size(), e_addr.size());
    n = (g_addr.size() < e_addr.size()) ? g_addr.size() : e_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {24'd0, g_addr[i]}, {24'd0, e_addr[i]});
      chk($sformatf("%s_data%0d", tag, i), {12'd0, g_data[i]}, {12'd0, e_data[i]});
    end
    chk({tag, "_done"},      {31'd0, done},      {31'd0, !err});
    chk({tag, "_error"},     {31'd0, error},     {31'd0, err});
    chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, !err});
    chk({tag, "_word_count"}, {23'd0, word_count}, wc);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
    chk({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
    chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_done"},      {31'd0, done},      32'd0);
    chk({tag, "_error"},     {31'd0, error},     32'd0);
    chk({tag, "_word_count"}, {23'd0, word_count}, 32'd0);
  endtask

  initial begin
    int nw;
    int fault;
    int k;
    logic [7:0] tmp;

    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("idle");
    @(posedge clk);
    #1;

    // Basic two-word image, back-to-back and with valid toggling.
    clear_stream();
    add_byte(8'h13, 0); add_byte(8'h00, 0); add_byte(8'h00, 0);
    add_byte(8'h25, 0); add_byte(8'h01, 0); add_byte(8'h00, 1);
    add_cs();
    run_load("basic", 0);
    run_load("toggle", 1);

    // Truncated image.
    clear_stream();
    add_byte(8'hAA, 0); add_byte(8'hBB, 1);
    run_load("trunc", 0);

    // Nonzero pad bits, then recovery with a clean image.
    clear_stream();
    add_byte(8'h34, 0); add_byte(8'h12, 0); add_byte(8'h1F, 1);
    run_load("pad", 0);
    clear_stream();
    add_word(20'hABCDE, 0); add_word(20'h00777, 1);
    add_cs();
    run_load("recover", -1);

    // Full memory with no end marker: 256 writes then overflow error.
    clear_stream();
    for (int i = 0; i < 259; i++) add_word(20'($urandom), i == 258);
    run_load("overflow", 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    clear_stream();
    add_byte(8'h01, 0); add_byte(8'h02, 0); add_byte(8'h03, 1); add_byte(8'h00, 1);
    run_load("cs_good", 0);
    clear_stream();
    add_byte(8'h01, 0); add_byte(8'h02, 0); add_byte(8'h03, 1); add_byte(8'h05, 0);
    run_load("cs_bad", 0);
`endif

    // Randomized images with occasional injected faults.
    for (int it = 0; it < 24; it++) begin
      clear_stream();
      nw    = $urandom_range(1, 6);
      fault = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) add_word(20'($urandom), w == nw - 1);
      add_cs();
      k = $urandom_range(0, nw - 1);
      if (fault == 2) begin
        tmp = 8'($urandom_range(1, 15));
        s_data[3*k+2] = s_data[3*k+2] | {tmp[3:0], 4'h0};
      end else if (fault == 3) begin
        s_last[3*k + $urandom_range(0, 1)] = 1'b1;
      end else if (fault == 4) begin
        tmp = 8'($urandom_range(1, 255));
        s_data[s_data.size()-1] = s_data[s_data.size()-1] ^ tmp;
      end
      run_load($sformatf("rand%0d", it), -1);
    end

    // Asynchronous reset in the middle of a load.
    clear_stream();
    for (int w = 0; w < 4; w++) add_word(20'($urandom), w == 3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) send(s_data[i], 1'b0, 0);
    rst = 1'b0;
    #1;
    check_all_zero("midreset_now");
    @(negedge clk);
    check_all_zero("midreset_next");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_stream();
    add_word(20'h12345, 0); add_word(20'h0000F, 1);
    add_cs();
    run_load("after_reset", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
